// File: rtl/timing_test_sched.sv
// Measurement scheduler for the inverter-chain timing test: runs the
// test cfg_runs times and accumulates sum/min/max of the error counts.
//
// Ports:
//   clk, rst          - clock, async active-high reset
//   start, abort      - begin a sequence (IDLE only) / cancel it
//   cfg_runs, cfg_gap - run count and idle cycles between runs
//   tt_we             - trigger to the timing test, ARM_LEN cycles per run
//   tt_done, tt_err   - completion pulse and error count from the test
//   busy, done        - sequence in progress / one-cycle completion pulse
//   timeout_err       - last sequence ended on a WAIT timeout
//   runs_done         - completed runs
//   err_sum, err_min, err_max - statistics over completed runs
module timing_test_sched #(
  parameter int RES_W   = 10,
  parameter int RUNS_W  = 8,
  parameter int ARM_LEN = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [RUNS_W-1:0]       cfg_runs,
  input  logic [15:0]             cfg_gap,
  output logic                    tt_we,
  input  logic                    tt_done,
  input  logic [RES_W-1:0]        tt_err,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [RUNS_W-1:0]       runs_done,
  output logic [RES_W+RUNS_W-1:0] err_sum,
  output logic [RES_W-1:0]        err_min,
  output logic [RES_W-1:0]        err_max
);

  localparam int AW = (ARM_LEN > 1) ? $clog2(ARM_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = RES_W + RUNS_W;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    GAP,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [AW-1:0]     arm_cnt;
  logic [TW-1:0]     wait_cnt;
  logic [15:0]       gap_cnt;
  logic [RUNS_W-1:0] runs_lat;
  logic [15:0]       gap_lat;

  logic              accept;
  logic              upd;
  logic              tmo;
  logic              tmo_hit;
  logic              arm_last;
  logic              gap_last;
  logic [RUNS_W-1:0] runs_nx;

  assign arm_last = (arm_cnt == AW'(ARM_LEN - 1));
  assign gap_last = (gap_cnt == gap_lat - 16'd1);
  assign tmo      = (wait_cnt == TW'(TIMEOUT - 1));
  assign runs_nx  = runs_done + RUNS_W'(1);

  assign accept  = (state == IDLE) && start;
  // abort wins over a simultaneous tt_done or timeout
  assign upd     = (state == WAIT) && tt_done && !abort;
  assign tmo_hit = (state == WAIT) && !tt_done && !abort && tmo;

  assign tt_we = (state == ARM);
  assign busy  = (state == ARM) || (state == WAIT) || (state == GAP);
  assign done  = (state == FINISH);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (cfg_runs == '0) ? FINISH : ARM;
      end
      ARM: begin
        if (abort)
          state_nx = IDLE;
        else if (arm_last)
          state_nx = WAIT;
      end
      WAIT: begin
        if (abort)
          state_nx = IDLE;
        else if (tt_done) begin
          if (runs_nx == runs_lat)
            state_nx = FINISH;
          else if (gap_lat == 16'd0)
            state_nx = ARM;
          else
            state_nx = GAP;
        end else if (tmo)
          state_nx = FINISH;
      end
      GAP: begin
        if (abort)
          state_nx = IDLE;
        else if (gap_last)
          state_nx = ARM;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // every state is entered from a different one, so the counters
  // restart simply by being held at zero outside their own state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt  <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      runs_lat <= '0;
      gap_lat  <= '0;
    end else begin
      arm_cnt  <= (state == ARM) ? arm_cnt + AW'(1) : '0;
      wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
      gap_cnt  <= (state == GAP) ? gap_cnt + 16'd1 : '0;
      if (accept) begin
        runs_lat <= cfg_runs;
        gap_lat  <= cfg_gap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      runs_done   <= '0;
      err_sum     <= '0;
      err_min     <= '1;
      err_max     <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      runs_done   <= '0;
      err_sum     <= '0;
      err_min     <= '1;
      err_max     <= '0;
      timeout_err <= 1'b0;
    end else if (upd) begin
      runs_done <= runs_nx;
      // SW bits hold (2^RUNS_W-1)*(2^RES_W-1) without wrap
      err_sum   <= err_sum + SW'(tt_err);
      if (tt_err < err_min)
        err_min <= tt_err;
      if (tt_err > err_max)
        err_max <= tt_err;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timing_test_sched.sv
// Directed bench for timing_test_sched: table of run sequences plus
// hand sequences for zero runs, timeout, abort, ignored inputs, reset.
module tb_timing_test_sched;

  localparam int RES_W   = 10;
  localparam int RUNS_W  = 8;
  localparam int ARM_LEN = 3;
  localparam int TIMEOUT = 4096;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    abort;
  logic [RUNS_W-1:0]       cfg_runs;
  logic [15:0]             cfg_gap;
  logic                    tt_we;
  logic                    tt_done;
  logic [RES_W-1:0]        tt_err;
  logic                    busy;
  logic                    done;
  logic                    timeout_err;
  logic [RUNS_W-1:0]       runs_done;
  logic [RES_W+RUNS_W-1:0] err_sum;
  logic [RES_W-1:0]        err_min;
  logic [RES_W-1:0]        err_max;

  timing_test_sched #(
    .RES_W  (RES_W),
    .RUNS_W (RUNS_W),
    .ARM_LEN(ARM_LEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_runs   (cfg_runs),
    .cfg_gap    (cfg_gap),
    .tt_we      (tt_we),
    .tt_done    (tt_done),
    .tt_err     (tt_err),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .runs_done  (runs_done),
    .err_sum    (err_sum),
    .err_min    (err_min),
    .err_max    (err_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   runs;
    int                   gap;
    int                   wdly;
    logic [3:0][RES_W-1:0] err;
    int                   sum;
    int                   emin;
    int                   emax;
  } vec_t;

  vec_t vecs[4];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int runs, input int gap,
                              input int wdly,
                              input logic [RES_W-1:0] e0,
                              input logic [RES_W-1:0] e1,
                              input logic [RES_W-1:0] e2,
                              input logic [RES_W-1:0] e3,
                              input int sum, input int emin,
                              input int emax);
    vec_t v;
    v.runs   = runs;
    v.gap    = gap;
    v.wdly   = wdly;
    v.err[0] = e0;
    v.err[1] = e1;
    v.err[2] = e2;
    v.err[3] = e3;
    v.sum    = sum;
    v.emin   = emin;
    v.emax   = emax;
    return v;
  endfunction

  task automatic check_rst(input string tag);
    chk({tag, "_we"}, 32'(tt_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    chk({tag, "_runs"}, 32'(runs_done), 32'd0);
    chk({tag, "_sum"}, 32'(err_sum), 32'd0);
    chk({tag, "_min"}, 32'(err_min), 32'd1023);
    chk({tag, "_max"}, 32'(err_max), 32'd0);
  endtask

  // returns at the negedge of the first WAIT cycle
  task automatic wait_we_fall(input string tag);
    int n;
    n = 0;
    while (!tt_we && n < 50) begin
      tick;
      n++;
    end
    while (tt_we && n < 50) begin
      tick;
      n++;
    end
    chk({tag, "_wait"}, 32'(n < 50), 32'd1);
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    int   cyc;
    int   we_cnt;
    int   idx;
    int   wcnt;
    int   done_at;
    int   exp_lat;
    logic prev_we;
    logic [RES_W+RUNS_W-1:0] sum_hold;
    cfg_runs = RUNS_W'(v.runs);
    cfg_gap  = 16'(v.gap);
    start    = 1'b1;
    tick;
    start   = 1'b0;
    cyc     = 1;
    we_cnt  = 0;
    idx     = 0;
    wcnt    = -1;
    done_at = -1;
    prev_we = 1'b0;
    while (cyc < 300 && done_at < 0) begin
      tt_done = 1'b0;
      if (done)
        done_at = cyc;
      else begin
        if (tt_we)
          we_cnt++;
        if (prev_we && !tt_we)
          wcnt = 0;
        if (wcnt >= 0) begin
          if (wcnt == v.wdly) begin
            tt_done = 1'b1;
            tt_err  = v.err[idx];
            if (idx < 3)
              idx++;
            wcnt = -1;
          end else
            wcnt++;
        end
        prev_we = tt_we;
        tick;
        cyc++;
      end
    end
    exp_lat = v.runs * (ARM_LEN + 1 + v.wdly) + (v.runs - 1) * v.gap + 1;
    chk({tag, "_lat"}, 32'(done_at), 32'(exp_lat));
    chk({tag, "_we_cycles"}, 32'(we_cnt), 32'(v.runs * ARM_LEN));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_runs"}, 32'(runs_done), 32'(v.runs));
    chk({tag, "_sum"}, 32'(err_sum), 32'(v.sum));
    chk({tag, "_min"}, 32'(err_min), 32'(v.emin));
    chk({tag, "_max"}, 32'(err_max), 32'(v.emax));
    chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    sum_hold = err_sum;
    tick;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    tick;
    chk({tag, "_hold"}, 32'(err_sum), 32'(sum_hold));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cfg_runs = '0;
    cfg_gap  = '0;
    tt_done  = 1'b0;
    tt_err   = '0;

    vecs[0] = mk(3, 2, 0, 10'd5, 10'd9, 10'd1, 10'd0, 15, 1, 9);
    vecs[1] = mk(2, 0, 3, 10'd100, 10'd40, 10'd0, 10'd0, 140, 40, 100);
    vecs[2] = mk(1, 5, 1, 10'd1023, 10'd0, 10'd0, 10'd0, 1023, 1023, 1023);
    vecs[3] = mk(4, 1, 0, 10'd0, 10'd1023, 10'd512, 10'd7, 1542, 0, 1023);

    #12;
    check_rst("por");
    tick;
    rst = 1'b0;
    tick;

    for (int i = 0; i < 4; i++)
      run_seq(vecs[i], $sformatf("vec%0d", i));

    // zero runs: straight to FINISH
    cfg_runs = '0;
    cfg_gap  = 16'd3;
    start    = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_we", 32'(tt_we), 32'd0);
    chk("zero_sum", 32'(err_sum), 32'd0);
    chk("zero_min", 32'(err_min), 32'd1023);
    chk("zero_runs", 32'(runs_done), 32'd0);
    tick;
    chk("zero_done_off", 32'(done), 32'd0);
    chk("zero_busy2", 32'(busy | tt_we), 32'd0);

    // timeout on first run
    cfg_runs = 8'd2;
    cfg_gap  = 16'd0;
    start    = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (!done && n < 5000) begin
      tick;
      n++;
    end
    chk("tmo_lat", 32'(n), 32'(ARM_LEN + TIMEOUT + 1));
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_runs", 32'(runs_done), 32'd0);
    chk("tmo_sum", 32'(err_sum), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    tick;

    // abort together with tt_done on run 2 of 4
    cfg_runs = 8'd4;
    cfg_gap  = 16'd1;
    start    = 1'b1;
    tick;
    start = 1'b0;
    chk("ab_tmo_clr", 32'(timeout_err), 32'd0);
    wait_we_fall("ab1");
    tt_done = 1'b1;
    tt_err  = 10'd20;
    tick;
    tt_done = 1'b0;
    wait_we_fall("ab2");
    tt_done = 1'b1;
    tt_err  = 10'd30;
    abort   = 1'b1;
    tick;
    tt_done = 1'b0;
    abort   = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_we", 32'(tt_we), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_runs", 32'(runs_done), 32'd1);
    chk("ab_sum", 32'(err_sum), 32'd20);
    chk("ab_min", 32'(err_min), 32'd20);
    chk("ab_max", 32'(err_max), 32'd20);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen = seen | done | busy;
    end
    chk("ab_idle", 32'(seen), 32'd0);

    // tt_done in ARM/GAP and start while busy are ignored
    cfg_runs = 8'd2;
    cfg_gap  = 16'd3;
    start    = 1'b1;
    tick;
    tt_done  = 1'b1;
    tt_err   = 10'd1;
    cfg_runs = 8'd1;
    cfg_gap  = 16'd0;
    tick;
    tt_done = 1'b0;
    chk("ig_arm_runs", 32'(runs_done), 32'd0);
    chk("ig_arm_sum", 32'(err_sum), 32'd0);
    chk("ig_arm_min", 32'(err_min), 32'd1023);
    chk("ig_arm_we", 32'(tt_we), 32'd1);
    wait_we_fall("ig1");
    tt_done = 1'b1;
    tt_err  = 10'd50;
    tick;
    tt_err = 10'd2;
    tick;
    tt_done = 1'b0;
    chk("ig_gap_runs", 32'(runs_done), 32'd1);
    chk("ig_gap_sum", 32'(err_sum), 32'd50);
    chk("ig_gap_min", 32'(err_min), 32'd50);
    chk("ig_gap_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_we_fall("ig2");
    tt_done = 1'b1;
    tt_err  = 10'd60;
    tick;
    tt_done = 1'b0;
    chk("ig_done", 32'(done), 32'd1);
    chk("ig_runs", 32'(runs_done), 32'd2);
    chk("ig_sum", 32'(err_sum), 32'd110);
    chk("ig_min", 32'(err_min), 32'd50);
    chk("ig_max", 32'(err_max), 32'd60);
    tick;

    // reset during WAIT of run 2
    cfg_runs = 8'd2;
    cfg_gap  = 16'd0;
    start    = 1'b1;
    tick;
    start = 1'b0;
    wait_we_fall("rs1");
    tt_done = 1'b1;
    tt_err  = 10'd77;
    tick;
    tt_done = 1'b0;
    chk("rs_runs1", 32'(runs_done), 32'd1);
    wait_we_fall("rs2");
    chk("rs_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_busy_async", 32'(busy), 32'd0);
    check_rst("rs");
    tick;
    rst = 1'b0;
    run_seq(vecs[0], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timing_test_sched.md
TIMING_TEST_SCHED -- requirements
Module: timing_test_sched

Interface
REQ-001 SHALL have parameter RES_W, default 10: width of one run's error count.
REQ-002 SHALL have parameter RUNS_W, default 8: width of the run-count configuration and counter.
REQ-003 SHALL have parameter ARM_LEN, default 3: number of cycles tt_we is held per run.
REQ-004 SHALL have parameter TIMEOUT, default 4096: maximum cycles spent in WAIT per run.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request a measurement sequence; sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1: cancel the running sequence.
REQ-009 SHALL have port cfg_runs, input, RUNS_W: number of runs; sampled at start acceptance.
REQ-010 SHALL have port cfg_gap, input, 16: idle cycles between runs; sampled at start acceptance.
REQ-011 SHALL have port tt_we, output, 1: trigger to the inverter-chain timing test.
REQ-012 SHALL have port tt_done, input, 1: one-cycle pulse; the timing test has finished counting.
REQ-013 SHALL have port tt_err, input, RES_W: error count from the timing test; valid while tt_done=1.
REQ-014 SHALL have port busy, output, 1: a sequence is in progress.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port timeout_err, output, 1: the last sequence ended by timeout.
REQ-017 SHALL have port runs_done, output, RUNS_W: completed runs in the current or last sequence.
REQ-018 SHALL have port err_sum, output, RES_W+RUNS_W: sum of tt_err over completed runs.
REQ-019 SHALL have ports err_min and err_max, output, RES_W each: minimum and maximum tt_err over completed runs.

Function
REQ-020 SHALL implement states IDLE, ARM, WAIT, GAP and FINISH.
REQ-021 SHALL, in IDLE with start=1 and cfg_runs!=0, latch cfg_runs and cfg_gap, clear the statistics and go to ARM.
- Cleared statistics: runs_done=0, err_sum=0, err_min=all ones, err_max=0, timeout_err=0.
REQ-022 SHALL, in IDLE with start=1 and cfg_runs==0, clear the statistics and go directly to FINISH.
REQ-023 SHALL drive busy=1 in ARM, WAIT and GAP, and busy=0 in IDLE and FINISH.
REQ-024 SHALL drive tt_we=1 for exactly ARM_LEN consecutive cycles in ARM, then go to WAIT.
- Timing: start accepted at cycle N gives tt_we high in cycles N+1 to N+ARM_LEN.
REQ-025 SHALL ignore tt_done in every state except WAIT.
REQ-026 SHALL, on tt_done in WAIT, update the statistics in the same edge.
- Updates: err_sum+=tt_err, err_min=min(err_min,tt_err), err_max=max(err_max,tt_err), runs_done+=1.
REQ-027 SHALL, after that update, go to FINISH if the new runs_done equals the latched cfg_runs, otherwise to GAP.
REQ-028 SHALL stay in GAP for exactly the latched cfg_gap cycles, then go to ARM; with cfg_gap=0 it SHALL go from WAIT to ARM directly.
REQ-029 SHALL count WAIT cycles per run, and after TIMEOUT cycles without tt_done set timeout_err=1 and go to FINISH.
- The statistics of completed runs are kept.
REQ-030 SHALL pulse done=1 for exactly one cycle in FINISH, then return to IDLE.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL, on abort=1 in ARM, WAIT or GAP, go to IDLE on the next edge with tt_we=0, no done pulse, and the statistics held.
REQ-033 SHALL give abort priority over a simultaneous tt_done or timeout.
REQ-034 SHALL keep err_sum free of overflow by its width, with no saturation logic.
REQ-035 SHALL hold all result outputs stable from FINISH until the next accepted start.

Reset
REQ-036 SHALL, while rst=1, force state IDLE and all outputs to 0, except err_min which SHALL be all ones.
REQ-037 SHALL clear all internal counters and latched configuration on reset.
REQ-038 SHALL, on reset asserted mid-sequence, drop tt_we and busy asynchronously, with no done pulse.

Verification
REQ-039 Bench SHALL cover: cfg_runs=3, cfg_gap=2, tt_err 5,9,1 -> tt_we asserted 3×3 cycles, done pulse, err_sum=15, err_min=1, err_max=9, runs_done=3, timeout_err=0.
REQ-040 Bench SHALL cover: cfg_runs=0, start -> done in the cycle after start, busy never 1, tt_we never 1, err_sum=0.
REQ-041 Bench SHALL cover: cfg_runs=2, no tt_done for the first run -> timeout_err=1 after 4096 WAIT cycles, done pulse, runs_done=0.
REQ-042 Bench SHALL cover: abort in the same cycle as tt_done on run 2 of 4 -> IDLE next cycle, runs_done=1, no done pulse.
REQ-043 Bench SHALL cover: tt_done during ARM or GAP, and start while busy -> both ignored, statistics unchanged.
REQ-044 Bench SHALL cover: rst asserted during WAIT -> tt_we=0 and busy=0 immediately, outputs at reset values, and a new start works normally.
